// File: rtl/cios_pkg.sv
// cios_pkg: shared types for the CIOS Montgomery row engine.
// Default sizing, FSM state encoding and index-width helper.
package cios_pkg;

  localparam int CIOS_W = 32;
  localparam int CIOS_S = 8;

  typedef logic [CIOS_W-1:0]   word_t;
  typedef logic [2*CIOS_W-1:0] dword_t;

  typedef enum logic [2:0] {
    IDLE,
    RUN0,
    MCALC,
    RUN,
    TAIL
  } state_e;

  function automatic int idx_w(input int s);
    return $clog2(s + 1);
  endfunction

endpackage

// File: rtl/cios_mac.sv
// cios_mac: registered {hi,lo} = x + y*z + c.
// Full 2*WIDTH result; the sum can never overflow.
module cios_mac #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [2*WIDTH-1:0] sum;

  assign sum = {{WIDTH{1'b0}}, x}
             + ({{WIDTH{1'b0}}, y} * {{WIDTH{1'b0}}, z})
             + {{WIDTH{1'b0}}, c};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hi <= '0;
      lo <= '0;
    end else if (en) begin
      {hi, lo} <= sum;
    end
  end

endmodule

// File: rtl/cios_row_pe.sv
// cios_row_pe: one CIOS outer iteration, word-serial.
// Stage A multiplies, stage B reduces, the tail folds carries for gamma_f.
module cios_row_pe
  import cios_pkg::*;
#(
  parameter int WIDTH = CIOS_W,
  parameter int S     = CIOS_S
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] n0_prime,
  input  logic [WIDTH-1:0] t_s,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] b_word,
  input  logic [WIDTH-1:0] n_word,
  input  logic [WIDTH-1:0] t_word,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             fin_valid,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] ts_out,
  output logic [WIDTH-1:0] ts1_out,
  output logic             busy
);

  localparam int CW = idx_w(S);

  typedef logic [WIDTH-1:0] w_t;
  typedef logic [CW-1:0]    c_t;

  state_e state, nxt;

  w_t   a_q, n0p_q, ts_q, n_q, m;
  w_t   sa, c1, sb, c2, out_hold;
  c_t   a_idx, b_idx;
  logic b_pend, ov, tail_d;
  logic start_go, accept, b_fire, inv_ok;

  assign start_go  = (state == IDLE) && start;
  assign accept    = in_valid && in_ready;
  assign b_fire    = b_pend && ((state == RUN) || (state == TAIL));
  assign busy      = (state != IDLE);
  assign out_valid = ov;
  assign out_word  = ov ? sb : out_hold;

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE:  if (start) nxt = RUN0;
      RUN0: begin
        in_ready = 1'b1;
        if (in_valid) nxt = MCALC;
      end
      MCALC: nxt = (S == 1) ? TAIL : RUN;
      RUN: begin
        in_ready = (a_idx < c_t'(S));
        if (b_fire && (b_idx == c_t'(S - 1))) nxt = TAIL;
      end
      TAIL:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  cios_mac #(.WIDTH(WIDTH)) u_mac_a (
    .clk (clk),
    .rst (rst),
    .en  (accept),
    .clr (start_go),
    .x   (t_word),
    .y   (a_q),
    .z   (b_word),
    .c   (c1),
    .hi  (c1),
    .lo  (sa)
  );

  cios_mac #(.WIDTH(WIDTH)) u_mac_b (
    .clk (clk),
    .rst (rst),
    .en  (b_fire),
    .clr (start_go),
    .x   (sa),
    .y   (m),
    .z   (n_q),
    .c   (c2),
    .hi  (c2),
    .lo  (sb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      n0p_q     <= '0;
      ts_q      <= '0;
      n_q       <= '0;
      m         <= '0;
      a_idx     <= '0;
      b_idx     <= '0;
      b_pend    <= 1'b0;
      ov        <= 1'b0;
      out_hold  <= '0;
      tail_d    <= 1'b0;
      fin_valid <= 1'b0;
      c_out     <= '0;
      ts_out    <= '0;
      ts1_out   <= '0;
    end else begin
      state <= nxt;
      if (start_go) begin
        a_q   <= a_word;
        n0p_q <= n0_prime;
        ts_q  <= t_s;
        a_idx <= '0;
        b_idx <= '0;
      end
      if (accept) begin
        a_idx <= a_idx + c_t'(1);
        n_q   <= n_word;
      end
      // word 0 waits out MCALC here until m is ready
      b_pend <= accept || (b_pend && !b_fire);
      if (b_fire) b_idx <= b_idx + c_t'(1);
      if (state == MCALC) m <= sa * n0p_q;
      ov <= b_fire && (b_idx != '0);
      if (ov) out_hold <= sb;
      // one cycle behind TAIL so an S=1 row sees its final C2
      tail_d    <= (state == TAIL);
      fin_valid <= tail_d;
      if (tail_d) begin
        {ts1_out, ts_out} <= {{WIDTH{1'b0}}, ts_q} + {{WIDTH{1'b0}}, c1};
        c_out             <= c2;
      end
    end
  end

  assign inv_ok = ((n0p_q * n_q) == '1);

  a_sb0_zero: assert property (@(posedge clk) disable iff (rst)
    (b_fire && (b_idx == '0) && inv_ok) |=> (sb == '0));

endmodule

// File: tb/tb_cios_row_pe.sv
// tb_cios_row_pe: directed vectors for the CIOS row engine.
// WIDTH=8 with an S=2 instance and an S=1 instance.
module tb_cios_row_pe;
  import cios_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, start1, in_valid;
  logic [7:0] a_word, n0_prime, t_s, b_word, n_word, t_word;

  logic       in_ready2, out_valid2, fin_valid2, busy2;
  logic [7:0] out_word2, c_out2, ts_out2, ts1_out2;
  logic       in_ready1, out_valid1, fin_valid1, busy1;
  logic [7:0] out_word1, c_out1, ts_out1, ts1_out1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_ov2 = 0;
  int n_ov1 = 0;
  logic [23:0] fin2_q[$];
  logic [23:0] fin1_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  cios_row_pe #(.WIDTH(8), .S(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start),
    .a_word(a_word), .n0_prime(n0_prime), .t_s(t_s),
    .in_valid(in_valid), .in_ready(in_ready2),
    .b_word(b_word), .n_word(n_word), .t_word(t_word),
    .out_valid(out_valid2), .out_word(out_word2),
    .fin_valid(fin_valid2), .c_out(c_out2),
    .ts_out(ts_out2), .ts1_out(ts1_out2), .busy(busy2)
  );

  cios_row_pe #(.WIDTH(8), .S(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .a_word(a_word), .n0_prime(n0_prime), .t_s(t_s),
    .in_valid(in_valid), .in_ready(in_ready1),
    .b_word(b_word), .n_word(n_word), .t_word(t_word),
    .out_valid(out_valid1), .out_word(out_word1),
    .fin_valid(fin_valid1), .c_out(c_out1),
    .ts_out(ts_out1), .ts1_out(ts1_out1), .busy(busy1)
  );

  always @(negedge clk) begin
    if (out_valid2) n_ov2++;
    if (out_valid1) n_ov1++;
    if (fin_valid2) fin2_q.push_back({c_out2, ts_out2, ts1_out2});
    if (fin_valid1) fin1_q.push_back({c_out1, ts_out1, ts1_out1});
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(
    input logic [7:0] a, n0p, ts, b0, b1, n0, n1, t0, t1,
    input int stall, input bit poke, input logic [7:0] exp_w);
    int s0;
    int k;
    s0       = cyc;
    start    = 1'b1;
    a_word   = a;
    n0_prime = n0p;
    t_s      = ts;
    tick();
    start = 1'b0;
    chk("rdy_run0", in_ready2, 1);
    chk("busy_run0", busy2, 1);
    in_valid = 1'b1;
    b_word   = b0;
    n_word   = n0;
    t_word   = t0;
    tick();
    chk("rdy_mcalc", in_ready2, 0);
    b_word   = b1;
    n_word   = n1;
    t_word   = t1;
    in_valid = (stall == 0);
    tick();
    if (poke) start = 1'b1;
    repeat (stall) begin
      tick();
      start = 1'b0;
    end
    in_valid = 1'b1;
    chk("rdy_run", in_ready2, 1);
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid2 && k < 8) begin
      tick();
      k++;
    end
    chk("ov_lat", k, 2);
    chk("ov_cyc", cyc - s0, 5 + stall);
    chk("out_word", out_word2, exp_w);
    tick();
  endtask

  task automatic check_fin(input bit one, input string tag,
                           input logic [7:0] c, s, s1);
    int k;
    int sz;
    logic [23:0] f;
    k  = 0;
    sz = one ? fin1_q.size() : fin2_q.size();
    while (sz == 0 && k < 20) begin
      tick();
      k++;
      sz = one ? fin1_q.size() : fin2_q.size();
    end
    chk({tag, "_fin_seen"}, 32'(sz > 0), 1);
    if (sz > 0) begin
      if (one) f = fin1_q.pop_front();
      else     f = fin2_q.pop_front();
      chk({tag, "_c_out"}, f[23:16], c);
      chk({tag, "_ts_out"}, f[15:8], s);
      chk({tag, "_ts1_out"}, f[7:0], s1);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    start1   = 1'b0;
    in_valid = 1'b0;
    a_word   = '0;
    n0_prime = '0;
    t_s      = '0;
    b_word   = '0;
    n_word   = '0;
    t_word   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_ov", out_valid2, 0);
    chk("rst_fin", fin_valid2, 0);
    chk("rst_ow", out_word2, 0);
    chk("rst_ts1", ts1_out2, 0);
    rst = 1'b0;
    tick();

    run_row(8'h01, 8'hCD, 8'h00, 8'h01, 8'h00, 8'hFB, 8'h00,
            8'h00, 8'h00, 0, 1'b0, 8'hC9);
    check_fin(1'b0, "basic", 8'h00, 8'h00, 8'h00);

    run_row(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
            8'hFF, 8'hFF, 0, 1'b0, 8'hFF);
    check_fin(1'b0, "maxc", 8'h00, 8'hFE, 8'h01);
    repeat (2) tick();
    chk("hold_ts", ts_out2, 8'hFE);
    chk("hold_ts1", ts1_out2, 8'h01);
    chk("hold_ow", out_word2, 8'hFF);
    chk("idle_busy", busy2, 0);

    run_row(8'h01, 8'hCD, 8'h00, 8'h01, 8'h00, 8'hFB, 8'h00,
            8'h00, 8'h00, 3, 1'b0, 8'hC9);
    check_fin(1'b0, "stall", 8'h00, 8'h00, 8'h00);

    run_row(8'h01, 8'hCD, 8'h00, 8'h01, 8'h00, 8'hFB, 8'h00,
            8'h00, 8'h00, 0, 1'b1, 8'hC9);
    check_fin(1'b0, "poke", 8'h00, 8'h00, 8'h00);

    run_row(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
            8'hFF, 8'hFF, 0, 1'b0, 8'hFF);
    check_fin(1'b0, "maxc2", 8'h00, 8'hFE, 8'h01);

    start    = 1'b1;
    a_word   = 8'h01;
    n0_prime = 8'hCD;
    t_s      = 8'h00;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    b_word   = 8'h01;
    n_word   = 8'hFB;
    t_word   = 8'h00;
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rm_state", u_dut2.state, IDLE);
    chk("rm_busy", busy2, 0);
    chk("rm_rdy", in_ready2, 0);
    chk("rm_ov", out_valid2, 0);
    chk("rm_fin", fin_valid2, 0);
    chk("rm_ow", out_word2, 0);
    chk("rm_c", c_out2, 0);
    chk("rm_ts", ts_out2, 0);
    chk("rm_ts1", ts1_out2, 0);
    rst = 1'b0;
    repeat (4) tick();
    chk("rm_nofin", fin2_q.size(), 0);

    run_row(8'h01, 8'hCD, 8'h00, 8'h01, 8'h00, 8'hFB, 8'h00,
            8'h00, 8'h00, 0, 1'b0, 8'hC9);
    check_fin(1'b0, "post_rst", 8'h00, 8'h00, 8'h00);

    run_row(8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00,
            8'hFF, 8'hFF, 0, 1'b0, 8'hFF);
    run_row(8'h01, 8'hCD, 8'h00, 8'h01, 8'h00, 8'hFB, 8'h00,
            8'h00, 8'h00, 0, 1'b0, 8'hC9);
    check_fin(1'b0, "b2b_0", 8'h00, 8'hFE, 8'h01);
    check_fin(1'b0, "b2b_1", 8'h00, 8'h00, 8'h00);

    repeat (3) tick();
    chk("ov_total", n_ov2, 8);
    chk("fin_extra", fin2_q.size(), 0);

    start1   = 1'b1;
    a_word   = 8'h02;
    n0_prime = 8'h00;
    t_s      = 8'h00;
    tick();
    start1   = 1'b0;
    chk("s1_rdy_run0", in_ready1, 1);
    in_valid = 1'b1;
    b_word   = 8'h03;
    n_word   = 8'h00;
    t_word   = 8'h01;
    tick();
    in_valid = 1'b0;
    chk("s1_sa0", u_dut1.sa, 8'h07);
    chk("s1_rdy_mcalc", in_ready1, 0);
    check_fin(1'b1, "s1", 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("s1_nov", n_ov1, 0);
    chk("s1_fin_extra", fin1_q.size(), 0);
    chk("s1_busy", busy1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
